// File: rtl/quiz_countdown_timer.sv
// quiz_countdown_timer
//   mm:ss countdown timer for the quiz game. The game FSM loads a start time,
//   starts/pauses/resumes it. An internal prescaler turns CLK_HZ clock cycles
//   into a one-second decrement. The block flags low time (warn) and expiry
//   (rem level + one-cycle expired_pulse). All outputs come straight from flops.
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   load, load_min/load_sec load strobe and time (seconds > 59 clamp to 59)
//   start, pause            control strobes (load > pause > start > tick)
//   minutes, seconds        remaining time for the 7-seg driver
//   running                 state is RUN
//   warn                    0 < remaining seconds <= WARN_SEC
//   rem                     state is EXPIRED
//   expired_pulse           one cycle on entry to EXPIRED
//   tick                    one cycle on every prescaler wrap while running
module quiz_countdown_timer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MIN_W       = 6,
  parameter int DEFAULT_MIN = 3,
  parameter int DEFAULT_SEC = 0,
  parameter int WARN_SEC    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             start,
  input  logic             pause,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             running,
  output logic             warn,
  output logic             rem,
  output logic             expired_pulse,
  output logic             tick
);

  localparam int PSC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_HZ - 1);
  // Total-seconds width: min*60 < 2^(MIN_W+6), plus 59 still fits.
  localparam int TW = MIN_W + 7;
  localparam logic [TW-1:0]    WARN_T  = TW'(WARN_SEC);
  localparam logic [MIN_W-1:0] DEF_MIN = MIN_W'(DEFAULT_MIN);
  localparam logic [5:0]       DEF_SEC = 6'(DEFAULT_SEC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_e;

  function automatic logic calc_warn(input logic [MIN_W-1:0] m, input logic [5:0] s);
    logic [TW-1:0] t;
    t = TW'(m) * TW'(60) + TW'(s);
    return (t <= WARN_T) && (t != '0);
  endfunction

  localparam logic DEF_WARN = calc_warn(DEF_MIN, DEF_SEC);

  state_e           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             running_q, running_d;
  logic             warn_q, warn_d;
  logic             rem_q, rem_d;
  logic             pulse_q, pulse_d;
  logic             tick_q, tick_d;

  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    if (load) begin
      min_d   = load_min;
      sec_d   = (load_sec > 6'd59) ? 6'd59 : load_sec;
      psc_d   = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            psc_d   = '0;
            // Starting at 0:00 expires at once so the game still sees a pulse.
            state_d = (min_q == '0 && sec_q == '0) ? S_EXPIRED : S_RUN;
          end
        end
        S_RUN: begin
          // pause beats a coincident wrap: prescaler parks at PSC_LAST so the
          // first RUN cycle after resume performs the skipped decrement.
          if (pause) begin
            state_d = S_PAUSED;
          end else if (psc_q == PSC_LAST) begin
            psc_d  = '0;
            tick_d = 1'b1;
            if (sec_q != '0) begin
              sec_d = sec_q - 6'd1;
            end else if (min_q != '0) begin
              min_d = min_q - MIN_W'(1);
              sec_d = 6'd59;
            end
            if (min_q == '0 && sec_q <= 6'd1) state_d = S_EXPIRED;
          end else begin
            psc_d = psc_q + PSC_W'(1);
          end
        end
        S_PAUSED: begin
          if (start) state_d = S_RUN;
        end
        S_EXPIRED: ;
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
    rem_d     = (state_d == S_EXPIRED);
    pulse_d   = (state_d == S_EXPIRED) && (state_q != S_EXPIRED);
    warn_d    = calc_warn(min_d, sec_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      psc_q     <= '0;
      min_q     <= DEF_MIN;
      sec_q     <= DEF_SEC;
      running_q <= 1'b0;
      warn_q    <= DEF_WARN;
      rem_q     <= 1'b0;
      pulse_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      warn_q    <= warn_d;
      rem_q     <= rem_d;
      pulse_q   <= pulse_d;
      tick_q    <= tick_d;
    end
  end

  assign minutes       = min_q;
  assign seconds       = sec_q;
  assign running       = running_q;
  assign warn          = warn_q;
  assign rem           = rem_q;
  assign expired_pulse = pulse_q;
  assign tick          = tick_q;

endmodule

// File: tb/tb_quiz_countdown_timer.sv
module tb_quiz_countdown_timer;
  localparam int CLK_HZ = 4;
  localparam int MIN_W  = 6;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [MIN_W-1:0] load_min = '0;
  logic [5:0]       load_sec = '0;
  logic [MIN_W-1:0] minutes;
  logic [5:0]       seconds;
  logic             running, warn, rem, expired_pulse, tick;

  quiz_countdown_timer #(.CLK_HZ(CLK_HZ), .MIN_W(MIN_W), .DEFAULT_MIN(3),
                         .DEFAULT_SEC(0), .WARN_SEC(10)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause), .minutes(minutes),
    .seconds(seconds), .running(running), .warn(warn), .rem(rem),
    .expired_pulse(expired_pulse), .tick(tick));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int mn; int sc; bit tk; bit ep; bit rm; bit wn; bit run;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int c, input int mn, input int sc, input bit tk,
                      input bit ep, input bit rm, input bit wn, input bit run);
    exp_t e;
    e.cyc = c; e.mn = mn; e.sc = sc; e.tk = tk; e.ep = ep; e.rm = rm; e.wn = wn; e.run = run;
    q.push_back(e);
  endtask

  // Monitor: every tick or expiry pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && (tick || expired_pulse)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event got tick=%0d pulse=%0d %0d:%0d at cyc %0d required none",
                 tick, expired_pulse, minutes, seconds, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("ev_cycle", cyc, mon_e.cyc);
        chk("ev_min", minutes, mon_e.mn);
        chk("ev_sec", seconds, mon_e.sc);
        chk("ev_tick", tick, mon_e.tk);
        chk("ev_pulse", expired_pulse, mon_e.ep);
        chk("ev_rem", rem, mon_e.rm);
        chk("ev_warn", warn, mon_e.wn);
        chk("ev_running", running, mon_e.run);
      end
    end
  end

  // Strobes are raised at a negedge and dropped just after the sampling edge;
  // s returns the cycle number of that sampling edge.
  task automatic do_load(input int mn, input int sc);
    @(negedge clk);
    load = 1'b1; load_min = MIN_W'(mn); load_sec = 6'(sc);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic do_start(output int s);
    @(negedge clk);
    s = cyc + 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_pause(output int s);
    @(negedge clk);
    s = cyc + 1; pause = 1'b1;
    @(posedge clk); #1;
    pause = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic chk_state(input string tag, input int mn, input int sc,
                           input int run, input int rm, input int wn);
    chk({tag, "_min"}, minutes, mn);
    chk({tag, "_sec"}, seconds, sc);
    chk({tag, "_running"}, running, run);
    chk({tag, "_rem"}, rem, rm);
    chk({tag, "_warn"}, warn, wn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, p, r, r2;
    // T1: reset values, then the first decrement CLK_HZ cycles after start
    #23;
    chk_state("rst", 3, 0, 0, 0, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pulse", expired_pulse, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk_state("idle", 3, 0, 0, 0, 0);
    do_start(s);
    chk("t1_running", running, 1);
    push(s + 4, 2, 59, 1, 0, 0, 0, 1);
    wait_until(s + 5);

    // T2: 0:02 counts to 0:00, expires once, later strobes ignored
    do_load(0, 2);
    chk_state("t2_load", 0, 2, 0, 0, 1);
    do_start(s);
    push(s + 4, 0, 1, 1, 0, 0, 1, 1);
    push(s + 8, 0, 0, 1, 1, 1, 0, 0);
    wait_until(s + 9);
    chk_state("t2_exp", 0, 0, 0, 1, 0);
    do_start(s);
    do_pause(p);
    wait_until(s + 10);
    chk_state("t2_hold", 0, 0, 0, 1, 0);

    // T3: pause keeps the partial second; pause on the wrap cycle skips it
    do_load(1, 0);
    do_start(s);
    wait_until(s + 1);
    do_pause(p);
    chk("t3_paused_running", running, 0);
    wait_until(p + 20);
    chk_state("t3_frozen", 1, 0, 0, 0, 0);
    do_start(r);
    push(r + 3, 0, 59, 1, 0, 0, 0, 1);
    wait_until(r + 6);
    do_pause(p);
    chk("t3_wrap_pause_tick", tick, 0);
    chk_state("t3_wrap_pause", 0, 59, 0, 0, 0);
    wait_until(p + 3);
    do_start(r2);
    push(r2 + 1, 0, 58, 1, 0, 0, 0, 1);
    wait_until(r2 + 2);

    // T4: warn window 0:10..0:01
    do_load(0, 12);
    chk_state("t4_load", 0, 12, 0, 0, 0);
    do_start(s);
    for (int k = 1; k <= 12; k++)
      push(s + 4 * k, 0, 12 - k, 1, k == 12, k == 12,
           ((12 - k) <= 10) && (k != 12), k != 12);
    wait_until(s + 49);
    chk_state("t4_end", 0, 0, 0, 1, 0);
    chk("t4_pulse_once", expired_pulse, 0);
    do_load(0, 5);
    chk_state("t4_idle_warn", 0, 5, 0, 0, 1);

    // T5: clamp, full-width minutes, load mid-run, 0:00 start
    do_load(0, 63);
    chk_state("t5_clamp", 0, 59, 0, 0, 0);
    do_load(63, 59);
    chk_state("t5_maxmin", 63, 59, 0, 0, 0);
    do_load(0, 40);
    do_start(s);
    for (int k = 1; k <= 10; k++) push(s + 4 * k, 0, 40 - k, 1, 0, 0, 0, 1);
    wait_until(s + 42);
    do_load(5, 7);
    chk_state("t5_reload", 5, 7, 0, 0, 0);
    do_start(s);
    push(s + 4, 5, 6, 1, 0, 0, 0, 1);
    wait_until(s + 5);
    do_load(0, 0);
    chk_state("t5_zero_load", 0, 0, 0, 0, 0);
    do_start(s);
    push(s, 0, 0, 0, 1, 1, 0, 0);
    wait_until(s + 2);
    chk_state("t5_zero_start", 0, 0, 0, 1, 0);

    // T6: asynchronous reset in the middle of a count
    do_load(0, 30);
    do_start(s);
    push(s + 4, 0, 29, 1, 0, 0, 0, 1);
    wait_until(s + 6);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_state("t6_async", 3, 0, 0, 0, 0);
    chk("t6_async_tick", tick, 0);
    chk("t6_async_pulse", expired_pulse, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_state("t6_held", 3, 0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk_state("t6_after", 3, 0, 0, 0, 0);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
